// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: clears x1..x31 after reset, then arbitrates ALU/LSU writebacks onto one RF write port.
// Define WB_RR_ARB_EN for round-robin conflict resolution; otherwise the LSU always wins a conflict.
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_wd,
    output logic        alu_ready,
    input  logic        lsu_valid,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_wd,
    output logic        lsu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wd,
    output logic        init_done
);
    typedef enum logic {INIT, RUN} state_t;
    state_t      r_state, w_state_nx;
    logic [4:0]  r_cnt;
    logic        r_we;
    logic [4:0]  r_rd;
    logic [31:0] r_wd;
    logic        w_alu_wins;
    logic        w_xfer;
    logic [4:0]  w_rd;
    logic [31:0] w_wd;
`ifdef WB_RR_ARB_EN
    logic r_last_lsu;
    assign w_alu_wins = r_last_lsu;
    always_ff @(posedge clk) begin
        if (rst)
            r_last_lsu <= 1'b1;
        else if (w_xfer)
            r_last_lsu <= lsu_ready;
    end
`else
    assign w_alu_wins = 1'b0;
`endif
    always_comb begin
        w_state_nx = (r_state == INIT && r_cnt == 5'd31) ? RUN : r_state;
        alu_ready  = !rst && r_state == RUN && alu_valid && (!lsu_valid || w_alu_wins);
        lsu_ready  = !rst && r_state == RUN && lsu_valid && !(alu_valid && w_alu_wins);
        w_xfer     = alu_ready || lsu_ready;
        w_rd       = alu_ready ? alu_rd : lsu_rd;
        w_wd       = alu_ready ? alu_wd : lsu_wd;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= INIT;
            r_cnt   <= 5'd1;
            r_we    <= 1'b0;
            r_rd    <= 5'd0;
            r_wd    <= 32'd0;
        end else begin
            r_state <= w_state_nx;
            if (r_state == INIT) begin
                r_cnt <= r_cnt + 5'd1;
                r_we  <= 1'b1;
                r_rd  <= r_cnt;
                r_wd  <= 32'd0;
            end else begin
                // x0 is hardwired: accept the transfer but suppress the write
                r_we <= w_xfer && w_rd != 5'd0;
                if (w_xfer) begin
                    r_rd <= w_rd;
                    r_wd <= w_wd;
                end
            end
        end
    end
    assign rf_we     = r_we;
    assign rf_rd     = r_rd;
    assign rf_wd     = r_wd;
    assign init_done = r_state == RUN;
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 Port clk  input  1  rising-edge clock for all state.
REQ-003 Port rst  input  1  synchronous active-high reset.
REQ-004 Port alu_valid  input  1  ALU writeback request.
REQ-005 Port alu_rd  input  5  ALU destination register index.
REQ-006 Port alu_wd  input  32  ALU write data.
REQ-007 Port alu_ready  output  1  ALU request accepted this cycle.
REQ-008 Port lsu_valid  input  1  load/store unit writeback request.
REQ-009 Port lsu_rd  input  5  LSU destination register index.
REQ-010 Port lsu_wd  input  32  LSU write data.
REQ-011 Port lsu_ready  output  1  LSU request accepted this cycle.
REQ-012 Port rf_we  output  1  register file write enable, registered.
REQ-013 Port rf_rd  output  5  register file write index, registered.
REQ-014 Port rf_wd  output  32  register file write data, registered.
REQ-015 Port init_done  output  1  high once the clear sequence has completed.

Function
REQ-016 The block SHALL implement a two-state FSM, INIT and RUN.
REQ-017 INIT: a 5-bit counter SHALL start at 1 and drive rf_we=1, rf_rd=counter, rf_wd=0 on the cycle after each count, incrementing once per cycle.
REQ-018 INIT: the counter SHALL advance from 1 to 31, producing exactly 31 clear writes (x1..x31). The FSM SHALL move to RUN after the write to x31 is issued. x0 SHALL never be written.
REQ-019 init_done SHALL go high in the first RUN cycle and stay high until reset.
REQ-020 alu_ready and lsu_ready SHALL be 0 in INIT. In RUN they are combinational from the valids and the arbitration state.
REQ-021 RUN: if exactly one requester is valid, that requester SHALL be granted (ready=1).
REQ-022 RUN: if both are valid, exactly one SHALL be granted per the arbitration policy (REQ-031/032). The loser's ready SHALL be 0.
REQ-023 A transfer occurs when valid && ready. Requesters SHALL hold valid, rd and wd stable until accepted.
REQ-024 On a transfer, rf_we/rf_rd/rf_wd SHALL present the granted rd/wd in the next cycle (latency 1), with rf_we=1.
REQ-025 A transfer with rd==0 SHALL be accepted (ready=1) but SHALL produce rf_we=0 in the next cycle.
REQ-026 With no transfer in a RUN cycle, rf_we SHALL be 0 in the next cycle. rf_rd and rf_wd hold their previous values.
REQ-027 Throughput SHALL be one write per cycle. Back-to-back transfers SHALL produce back-to-back rf_we pulses.

Reset
REQ-028 On rst=1 at a clock edge:
- state=INIT, counter=1, rf_we=0, rf_rd=0, rf_wd=0, init_done=0;
- round-robin pointer set so that ALU wins the first conflict.
REQ-029 Reset asserted mid-operation (INIT or RUN) SHALL drop any pending registered write: rf_we=0 in the cycle after the reset edge. The clear sequence SHALL then restart from x1 once rst deasserts.
REQ-030 While rst is high, alu_ready and lsu_ready SHALL be 0.

Configuration
REQ-031 With macro WB_RR_ARB_EN defined, conflicts SHALL be resolved round-robin:
- a 1-bit pointer records the last requester granted on any transfer;
- on a conflict, the other requester wins.
REQ-032 Without WB_RR_ARB_EN, conflicts SHALL be resolved by fixed priority: LSU always wins and no pointer is implemented.

Verification
REQ-033 Reset, then idle 40 cycles -> exactly 31 rf_we pulses with rf_rd=1..31 in order and rf_wd=0; init_done rises on the cycle after the x31 write; readys are 0 throughout INIT.
REQ-034 In RUN, alu_valid=1, alu_rd=5, alu_wd=42, one cycle -> alu_ready=1; next cycle rf_we=1, rf_rd=5, rf_wd=42.
REQ-035 In RUN, lsu_valid=1, lsu_rd=0, lsu_wd=7 -> lsu_ready=1; next cycle rf_we=0.
REQ-036 Both valid for 4 cycles (alu rd=3/wd=10, lsu rd=4/wd=20), requesters holding valid after acceptance:
- with WB_RR_ARB_EN: rf_rd sequence 3,4,3,4;
- without WB_RR_ARB_EN: rf_rd sequence 4,4,4,4 and alu_ready=0 throughout.
REQ-037 Assert rst for 1 cycle while in RUN with alu_valid=1, alu_rd=9 -> rf_we=0 on the following cycle, init_done=0, and the clear sequence restarts with rf_rd=1.
